watch_time_reporter: RTL

//  Reports the current watch time over UART. This is the reporting path

---
 rtl/watch_time_reporter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/watch_time_reporter.sv
// rtl/watch_time_reporter.sv - snapshots watch time and streams "HH:MM:SS.cc\r\n" to uart_tx
// Optional macro WATCH_RPT_AUTO_EN: a change of i_sec also requests a frame (one pending max).
module watch_time_reporter #(
  parameter bit FRAME_CRLF = 1'b1,
  parameter bit SHOW_MSEC  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy,
  output logic       o_done
);

  localparam int         FRAME_LEN = 9 + (SHOW_MSEC ? 3 : 0) + (FRAME_CRLF ? 1 : 0);
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_SEND, S_HOLD, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic [7:0]  data_q, data_d;
  logic [4:0]  hour_q;
  logic [5:0]  min_q, sec_q;
  logic [6:0]  msec_q;
  logic [3:0]  h1_q, h0_q, m1_q, m0_q, s1_q, s0_q, c1_q, c0_q;
  logic [7:0]  frame_byte;
  logic        tx_start;
  logic        req_take;

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

`ifdef WATCH_RPT_AUTO_EN
  logic [5:0] sec_prev_q;
  logic       pending_q, pending_d;
  logic       sec_chg;

  assign sec_chg  = (i_sec != sec_prev_q);
  assign req_take = i_req | sec_chg | pending_q;

  // Any second change seen while a frame is in flight is remembered once.
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_IDLE)
      pending_d = 1'b0;
    else if (sec_chg)
      pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_prev_q <= 6'd0;
      pending_q  <= 1'b0;
    end else begin
      sec_prev_q <= i_sec;
      pending_q  <= pending_d;
    end
  end
`else
  assign req_take = i_req;
`endif

  always_comb begin
    frame_byte = 8'h0A;
    case (idx_q)
      4'd0:       frame_byte = ascii(h1_q);
      4'd1:       frame_byte = ascii(h0_q);
      4'd2, 4'd5: frame_byte = 8'h3A;
      4'd3:       frame_byte = ascii(m1_q);
      4'd4:       frame_byte = ascii(m0_q);
      4'd6:       frame_byte = ascii(s1_q);
      4'd7:       frame_byte = ascii(s0_q);
      default: begin
        if (SHOW_MSEC && idx_q == 4'd8)
          frame_byte = 8'h2E;
        else if (SHOW_MSEC && idx_q == 4'd9)
          frame_byte = ascii(c1_q);
        else if (SHOW_MSEC && idx_q == 4'd10)
          frame_byte = ascii(c0_q);
        else if (FRAME_CRLF && idx_q == LAST_IDX - 4'd1)
          frame_byte = 8'h0D;
        else
          frame_byte = 8'h0A;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    data_d   = data_q;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: if (req_take) begin
        state_d = S_CONV;
        busy_d  = 1'b1;
      end
      S_CONV: begin
        idx_d   = 4'd0;
        state_d = S_SEND;
      end
      S_SEND: if (!i_tx_busy) begin
        tx_start = 1'b1;
        data_d   = frame_byte;
        state_d  = S_HOLD;
      end
      S_HOLD: state_d = S_WAIT;
      S_WAIT: if (!i_tx_busy) begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  // Clamped snapshot in IDLE, BCD split during CONV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q <= '0; min_q <= '0; sec_q <= '0; msec_q <= '0;
      h1_q <= '0; h0_q <= '0; m1_q <= '0; m0_q <= '0;
      s1_q <= '0; s0_q <= '0; c1_q <= '0; c0_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_take) begin
        hour_q <= (i_hour > 5'd23) ? 5'd23 : i_hour;
        min_q  <= (i_min  > 6'd59) ? 6'd59 : i_min;
        sec_q  <= (i_sec  > 6'd59) ? 6'd59 : i_sec;
        msec_q <= (i_msec > 7'd99) ? 7'd99 : i_msec;
      end
      if (state_q == S_CONV) begin
        h1_q <= bcd_tens(7'(hour_q)); h0_q <= bcd_ones(7'(hour_q));
        m1_q <= bcd_tens(7'(min_q));  m0_q <= bcd_ones(7'(min_q));
        s1_q <= bcd_tens(7'(sec_q));  s0_q <= bcd_ones(7'(sec_q));
        c1_q <= bcd_tens(msec_q);     c0_q <= bcd_ones(msec_q);
      end
    end
  end

  // The byte being offered is visible in SEND; afterwards the launched byte is held.
  assign o_tx_data  = (state_q == S_SEND) ? frame_byte : data_q;
  assign o_tx_start = tx_start;
  assign o_busy     = busy_q;
  assign o_done     = (state_q == S_DONE);

endmodule
